// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame engine.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Shortest and longest character lengths the engine can ever be built for.
  localparam int MIN_WLEN     = 5;
  localparam int ABS_MAX_WLEN = 9;

  // Expected parity bit for a received character (unused data bits must be 0).
  function automatic logic exp_parity(input logic [ABS_MAX_WLEN-1:0] data,
                                      input logic                    eps,
                                      input logic                    sp);
    logic p;
    if (sp)
      p = ~eps;
    else if (eps)
      p = ^data;
    else
      p = ~(^data);
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_majority_sampler.sv
// Serial source select, metastability synchroniser and 3-tap majority vote.
module uart_rx_majority_sampler
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic presetn,
  input  logic baud_tick,
  input  logic uart_rxd,
  input  logic loop_txd,
  input  logic loop,
  output logic rxd_sync,
  output logic rxd_voted
);

  logic                   w_serial_in;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [2:0]             r_taps;

  assign w_serial_in = loop ? loop_txd : uart_rxd;

  // Synchroniser chain; resets to the idle (high) line level.
  always_ff @(posedge pclk) begin
    if (presetn)
      r_sync <= '1;
    else
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_serial_in};
  end

  // Vote window: the last three oversamples, advanced only on baud_tick.
  always_ff @(posedge pclk) begin
    if (presetn)
      r_taps <= 3'b111;
    else if (baud_tick)
      r_taps <= {r_taps[1:0], r_sync[SYNC_STAGES-1]};
  end

  assign rxd_sync  = r_sync[SYNC_STAGES-1];
  assign rxd_voted = (r_taps[0] & r_taps[1]) | (r_taps[0] & r_taps[2]) |
                     (r_taps[1] & r_taps[2]);

endmodule

// File: rtl/uart_rx_frame_engine.sv
// Self-timed UART receive frame engine: oversampled FSM, deserialiser and
// per-character status (parity, framing, break).
module uart_rx_frame_engine
  import uart_rx_pkg::*;
#(
  parameter int DATA_MAX    = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                baud_tick,
  input  logic                uart_rxd,
  input  logic                loop_txd,
  input  logic                loop,
  input  logic [3:0]          word_len,
  input  logic                pen,
  input  logic                eps,
  input  logic                sp,
  output logic                rx_valid,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                parity_error,
  output logic                frame_error,
  output logic                break_det,
  output logic                rx_busy,
  output logic                rxd_voted
);

  localparam int            CW       = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  // Decision point: the vote window then covers the three centre samples.
  localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);

  rx_state_e             r_state, w_state_nxt;
  logic [CW-1:0]         r_sample_cnt, w_sample_cnt_nxt;
  logic [3:0]            r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]            r_len, w_len_nxt;
  logic                  r_pen, w_pen_nxt;
  logic                  r_eps, w_eps_nxt;
  logic                  r_sp, w_sp_nxt;
  logic [DATA_MAX-1:0]   r_shift, w_shift_nxt;
  logic                  r_par_bit, w_par_bit_nxt;
  logic                  r_tick_d;
  logic                  r_need_high, w_need_high_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [DATA_MAX-1:0]   r_data, w_data_nxt;
  logic                  r_pe, w_pe_nxt;
  logic                  r_fe, w_fe_nxt;
  logic                  r_bd, w_bd_nxt;

  logic                    w_rxd_sync;
  logic                    w_rxd_voted;
  logic                    w_dec;
  logic                    w_end_bit;
  logic [3:0]              w_len_clamped;
  logic [ABS_MAX_WLEN-1:0] w_data_ext;

  uart_rx_majority_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .pclk      (pclk),
    .presetn   (presetn),
    .baud_tick (baud_tick),
    .uart_rxd  (uart_rxd),
    .loop_txd  (loop_txd),
    .loop      (loop),
    .rxd_sync  (w_rxd_sync),
    .rxd_voted (w_rxd_voted)
  );

  // The vote is read one pclk after the tick that filled the window, so the
  // taps already hold the three centre samples of the bit.
  assign w_dec      = r_tick_d && (r_sample_cnt == CNT_DEC);
  assign w_end_bit  = baud_tick && (r_sample_cnt == CNT_LAST);
  assign w_data_ext = ABS_MAX_WLEN'(r_shift);

  // Clamp the requested character length into the supported range.
  always_comb begin
    w_len_clamped = word_len;
    if (word_len < 4'(MIN_WLEN))
      w_len_clamped = 4'(MIN_WLEN);
    else if (word_len > 4'(DATA_MAX))
      w_len_clamped = 4'(DATA_MAX);
  end

  // Next-state, counter, deserialiser and status logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_sample_cnt_nxt = r_sample_cnt;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_len_nxt        = r_len;
    w_pen_nxt        = r_pen;
    w_eps_nxt        = r_eps;
    w_sp_nxt         = r_sp;
    w_shift_nxt      = r_shift;
    w_par_bit_nxt    = r_par_bit;
    w_need_high_nxt  = r_need_high;
    w_valid_nxt      = 1'b0;
    w_data_nxt       = r_data;
    w_pe_nxt         = r_pe;
    w_fe_nxt         = r_fe;
    w_bd_nxt         = r_bd;

    if (baud_tick && (r_state != IDLE))
      w_sample_cnt_nxt = (r_sample_cnt == CNT_LAST) ? '0 : r_sample_cnt + CW'(1);

    case (r_state)
      IDLE: begin
        // After a low stop bit the line must be seen high before re-arming.
        if (w_rxd_voted)
          w_need_high_nxt = 1'b0;
        if (baud_tick && !w_rxd_sync && !r_need_high) begin
          w_state_nxt      = START;
          w_sample_cnt_nxt = '0;
          w_bit_cnt_nxt    = '0;
          w_len_nxt        = w_len_clamped;
          w_pen_nxt        = pen;
          w_eps_nxt        = eps;
          w_sp_nxt         = sp;
          w_shift_nxt      = '0;
          w_par_bit_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_dec && w_rxd_voted) begin
          w_state_nxt = IDLE;
        end else if (w_end_bit) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_dec) begin
          for (int i = 0; i < DATA_MAX; i++) begin
            if (r_bit_cnt == 4'(i))
              w_shift_nxt[i] = w_rxd_voted;
          end
        end
        if (w_end_bit) begin
          if (r_bit_cnt == r_len - 4'd1)
            w_state_nxt = r_pen ? PARITY : STOP;
          else
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
        end
      end
      PARITY: begin
        if (w_dec)
          w_par_bit_nxt = w_rxd_voted;
        if (w_end_bit)
          w_state_nxt = STOP;
      end
      STOP: begin
        // Leave half a bit early so the next start edge is never missed.
        if (w_dec) begin
          w_state_nxt     = IDLE;
          w_valid_nxt     = 1'b1;
          w_data_nxt      = r_shift;
          w_fe_nxt        = ~w_rxd_voted;
          w_pe_nxt        = r_pen & (r_par_bit != exp_parity(w_data_ext, r_eps, r_sp));
          w_bd_nxt        = (r_shift == '0) & (~r_pen | ~r_par_bit) & ~w_rxd_voted;
          w_need_high_nxt = ~w_rxd_voted;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state, counters and output status registers.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      r_state      <= IDLE;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_tick_d     <= 1'b0;
      r_need_high  <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_pe         <= 1'b0;
      r_fe         <= 1'b0;
      r_bd         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_tick_d     <= baud_tick;
      r_need_high  <= w_need_high_nxt;
      r_valid      <= w_valid_nxt;
      r_data       <= w_data_nxt;
      r_pe         <= w_pe_nxt;
      r_fe         <= w_fe_nxt;
      r_bd         <= w_bd_nxt;
    end
  end

  // Per-character datapath: latched config, shift register, parity sample.
  always_ff @(posedge pclk) begin
    r_len     <= w_len_nxt;
    r_pen     <= w_pen_nxt;
    r_eps     <= w_eps_nxt;
    r_sp      <= w_sp_nxt;
    r_shift   <= w_shift_nxt;
    r_par_bit <= w_par_bit_nxt;
  end

  assign rx_valid     = r_valid;
  assign rx_data      = r_data;
  assign parity_error = r_pe;
  assign frame_error  = r_fe;
  assign break_det    = r_bd;
  assign rx_busy      = (r_state != IDLE);
  assign rxd_voted    = w_rxd_voted;

endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Bench for uart_rx_frame_engine: directed vector table, hand-written corner
// sequences and randomized frames against a reference model.
module tb_uart_rx_frame_engine;

  localparam int OS       = 16;
  localparam int DIV      = 4;
  localparam int BIT_CLKS = OS * DIV;

  logic       pclk = 1'b0;
  logic       presetn = 1'b1;
  logic       baud_tick = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       loop_txd = 1'b1;
  logic       loop = 1'b1;
  logic [3:0] word_len = 4'd8;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sp = 1'b0;

  logic       rx_valid8, pe8, fe8, bd8, busy8, voted8;
  logic [7:0] rx_data8;
  logic       rx_valid9, pe9, fe9, bd9, busy9, voted9;
  logic [8:0] rx_data9;

  uart_rx_frame_engine #(.DATA_MAX(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut8 (
    .pclk(pclk), .presetn(presetn), .baud_tick(baud_tick), .uart_rxd(uart_rxd),
    .loop_txd(loop_txd), .loop(loop), .word_len(word_len), .pen(pen), .eps(eps),
    .sp(sp), .rx_valid(rx_valid8), .rx_data(rx_data8), .parity_error(pe8),
    .frame_error(fe8), .break_det(bd8), .rx_busy(busy8), .rxd_voted(voted8)
  );

  uart_rx_frame_engine #(.DATA_MAX(9), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut9 (
    .pclk(pclk), .presetn(presetn), .baud_tick(baud_tick), .uart_rxd(uart_rxd),
    .loop_txd(loop_txd), .loop(loop), .word_len(word_len), .pen(pen), .eps(eps),
    .sp(sp), .rx_valid(rx_valid9), .rx_data(rx_data9), .parity_error(pe9),
    .frame_error(fe9), .break_det(bd9), .rx_busy(busy9), .rxd_voted(voted9)
  );

  always #5 pclk = ~pclk;

  int div_cnt = 0;
  always @(negedge pclk) begin
    baud_tick = (div_cnt == DIV - 1);
    div_cnt   = (div_cnt + 1) % DIV;
  end

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bd;
  } ev_t;

  ev_t q8[$];
  ev_t q9[$];
  int  busy_cnt = 0;

  always @(negedge pclk) begin
    ev_t e;
    if (rx_valid8) begin
      e.data = {1'b0, rx_data8}; e.pe = pe8; e.fe = fe8; e.bd = bd8;
      q8.push_back(e);
    end
    if (busy8) busy_cnt++;
  end

  always @(negedge pclk) begin
    ev_t e;
    if (rx_valid9) begin
      e.data = rx_data9; e.pe = pe9; e.fe = fe9; e.bd = bd9;
      q9.push_back(e);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_ev(input string name, input int which, input ev_t x);
    ev_t e;
    int  n;
    n = (which == 9) ? q9.size() : q8.size();
    check({name, " count"}, n, 1);
    if (n > 0) begin
      e = (which == 9) ? q9[0] : q8[0];
      check({name, " data"}, e.data, x.data);
      check({name, " parity_error"}, e.pe, x.pe);
      check({name, " frame_error"}, e.fe, x.fe);
      check({name, " break_det"}, e.bd, x.bd);
    end
  endtask

  // Unselected source carries the inverted bit so a wrong mux is visible.
  task automatic drive_bit(input logic v);
    if (loop) begin loop_txd = v;  uart_rxd = ~v; end
    else      begin uart_rxd = v;  loop_txd = ~v; end
    repeat (BIT_CLKS) @(negedge pclk);
  endtask

  task automatic idle_bits(input int n);
    loop_txd = 1'b1;
    uart_rxd = 1'b1;
    repeat (n * BIT_CLKS) @(negedge pclk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input logic has_par,
                            input logic par, input logic stopb);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
    if (has_par) drive_bit(par);
    drive_bit(stopb);
    idle_bits(2);
  endtask

  // Reference: what a receiver of len-bit characters must report.
  function automatic ev_t model(input logic [8:0] d, input int len, input logic pen_i,
                                input logic eps_i, input logic sp_i, input logic par,
                                input logic stopb);
    ev_t        r;
    logic [8:0] m;
    logic       xp;
    m = d & ((9'd1 << len) - 9'd1);
    if (sp_i)
      xp = ~eps_i;
    else if (($countones(m) % 2) == 1)
      xp = eps_i;
    else
      xp = ~eps_i;
    r.data = m;
    r.pe   = pen_i && (par != xp);
    r.fe   = !stopb;
    r.bd   = (m == 9'd0) && (!pen_i || !par) && !stopb;
    return r;
  endfunction

  typedef struct {
    logic [8:0] data;
    int         nbits;
    logic [3:0] wl;
    logic       pen, eps, sp, par, stopb;
    logic       chk8, chk9;
    logic [8:0] xd;
    logic       xpe, xfe, xbd;
  } vec_t;

  vec_t vt[9];

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ev_t x;
    int  b0;
    int  wl;

    //           data   n  wl    pen   eps   sp    par   stop  c8    c9    xd     xpe   xfe   xbd
    vt[0] = '{9'h0A5, 8, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vt[1] = '{9'h055, 7, 4'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'h055, 1'b1, 1'b0, 1'b0};
    vt[2] = '{9'h01F, 5, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h01F, 1'b0, 1'b1, 1'b0};
    vt[3] = '{9'h000, 8, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0};
    vt[4] = '{9'h0C3, 8, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'h0C3, 1'b0, 1'b0, 1'b0};
    vt[5] = '{9'h00B, 5, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 9'h00B, 1'b0, 1'b0, 1'b0};
    vt[6] = '{9'h080, 8, 4'd8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h080, 1'b1, 1'b0, 1'b0};
    vt[7] = '{9'h000, 8, 4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b1, 1'b1};
    vt[8] = '{9'h1A5, 9, 4'd9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'h1A5, 1'b0, 1'b0, 1'b0};

    // Reset state
    presetn = 1'b1;
    repeat (5) @(negedge pclk);
    check("reset rx_valid", rx_valid8, 0);
    check("reset rx_data", rx_data8, 0);
    check("reset errors", {pe8, fe8, bd8}, 0);
    check("reset rx_busy", busy8, 0);
    check("reset rxd_voted", voted8, 1);
    check("reset rxd_voted9", voted9, 1);
    presetn = 1'b0;
    idle_bits(2);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      word_len = vt[i].wl; pen = vt[i].pen; eps = vt[i].eps; sp = vt[i].sp;
      q8.delete(); q9.delete();
      send_frame(vt[i].data, vt[i].nbits, vt[i].pen, vt[i].par, vt[i].stopb);
      x.data = vt[i].xd; x.pe = vt[i].xpe; x.fe = vt[i].xfe; x.bd = vt[i].xbd;
      if (vt[i].chk8) check_ev($sformatf("vec%0d dut8", i), 8, x);
      if (vt[i].chk9) check_ev($sformatf("vec%0d dut9", i), 9, x);
      if (vt[i].chk8) check($sformatf("vec%0d busy_after", i), busy8, 0);
    end

    // Break: line low for two character times
    word_len = 4'd8; pen = 1'b0; eps = 1'b0; sp = 1'b0;
    q8.delete();
    loop_txd = 1'b0; uart_rxd = 1'b1;
    repeat (20 * BIT_CLKS) @(negedge pclk);
    x.data = 9'h000; x.pe = 1'b0; x.fe = 1'b1; x.bd = 1'b1;
    check_ev("break", 8, x);
    idle_bits(2);
    check("break no_retrigger", q8.size(), 1);
    q8.delete();
    send_frame(9'h03A, 8, 1'b0, 1'b0, 1'b1);
    x.data = 9'h03A; x.fe = 1'b0; x.bd = 1'b0;
    check_ev("after_break", 8, x);

    // Short low glitch is a false start
    q8.delete();
    b0 = busy_cnt;
    loop_txd = 1'b0;
    repeat (4 * DIV) @(negedge pclk);
    loop_txd = 1'b1;
    repeat (BIT_CLKS) @(negedge pclk);
    check("glitch busy_pulsed", (busy_cnt > b0), 1);
    check("glitch no_valid", q8.size(), 0);
    check("glitch busy_after", busy8, 0);
    send_frame(9'h06D, 8, 1'b0, 1'b0, 1'b1);
    x.data = 9'h06D;
    check_ev("after_glitch", 8, x);

    // Reset in the middle of a character
    q8.delete();
    send_frame(9'h081, 8, 1'b0, 1'b0, 1'b1);
    x.data = 9'h081;
    check_ev("pre_reset", 8, x);
    q8.delete();
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    loop_txd = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    check("midreset rx_data", rx_data8, 0);
    check("midreset rx_busy", busy8, 0);
    check("midreset errors", {pe8, fe8, bd8}, 0);
    check("midreset rxd_voted", voted8, 1);
    idle_bits(8);
    check("midreset no_valid", q8.size(), 0);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1);
    x.data = 9'h03C;
    check_ev("after_reset", 8, x);

    // Randomized frames against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [8:0] d;
      logic       par, stopb;
      loop     = 1'($urandom_range(0, 1));
      wl       = $urandom_range(0, 8);
      word_len = 4'(wl);
      pen      = 1'($urandom_range(0, 1));
      eps      = 1'($urandom_range(0, 1));
      sp       = 1'($urandom_range(0, 1));
      par      = 1'($urandom_range(0, 1));
      stopb    = ($urandom_range(0, 4) != 0);
      d        = 9'($urandom);
      if (wl < 5) wl = 5;
      x = model(d, wl, pen, eps, sp, par, stopb);
      q8.delete(); q9.delete();
      send_frame(d, wl, pen, par, stopb);
      check_ev($sformatf("rand%0d dut8", i), 8, x);
      check_ev($sformatf("rand%0d dut9", i), 9, x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_engine.md
Name: uart_rx_frame_engine

Overview:
Parametrised, self-timed UART receive frame engine. It replaces an externally sequenced shift/vote datapath with an internal oversampling state machine. Covers input synchronisation, 3-tap majority voting, start-bit validation, LSB-first deserialisation of 5..DATA_MAX bits, optional normal/stick parity, and frame/break detection. It sits between the RXD pin (or the transmitter loopback) and the receive FIFO/LSR logic, and presents one-cycle-valid characters with per-character status.

Parameters:
DATA_MAX, 8, maximum data bits per character (legal 5..9); sets rx_data width.
OVERSAMPLE, 16, baud_tick pulses per bit (even, >=8).
SYNC_STAGES, 2, synchroniser flops on the serial input (>=2).

Ports:
pclk  input  1  UART clock; all logic on the rising edge.
presetn  input  1  reset: synchronous, active-high (1 = reset).
baud_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate.
uart_rxd  input  1  serial input from the pin, asynchronous.
loop_txd  input  1  transmitter serial output for loopback.
loop  input  1  1 = use loop_txd as the serial source.
word_len  input  4  data bits per character; clamped to 5..DATA_MAX.
pen  input  1  parity enable.
eps  input  1  even parity select (1 = even, 0 = odd).
sp  input  1  stick parity; expected parity bit = ~eps.
rx_valid  output  1  one-pclk pulse: character and status valid.
rx_data  output  DATA_MAX  received character, right-aligned, upper bits 0.
parity_error  output  1  qualified by rx_valid.
frame_error  output  1  first stop bit voted 0; qualified by rx_valid.
break_det  output  1  all data, parity and stop bits 0; qualified by rx_valid.
rx_busy  output  1  1 whenever the state is not IDLE.
rxd_voted  output  1  current majority-voted line value (debug/status).

Behaviour:
- Source mux: serial_in = loop ? loop_txd : uart_rxd, placed before the synchroniser. Synchroniser flops reset to 1 (idle line).
- Vote: 3-tap shift of the synced line, advanced only on baud_tick. rxd_voted = majority of the 3 taps; taps reset to 111.
- Counters: sample_cnt counts 0..OVERSAMPLE-1 and advances on baud_tick; bit_cnt counts data bits.
- Bit decision: the voted value at sample_cnt == OVERSAMPLE/2+1, i.e. the taps span samples OVERSAMPLE/2-1..OVERSAMPLE/2+1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a baud_tick with the synced line 0, go to START and set sample_cnt = 0. Latch word_len (clamped), pen, eps and sp. Config changes mid-frame have no effect.
- START: at the decision point, a voted 1 is a false start -> IDLE, with no rx_valid and no status. Otherwise, at sample_cnt == OVERSAMPLE-1 go to DATA with bit_cnt = 0.
- DATA: at each decision point, shift the bit in LSB-first. At the end of the bit, if bit_cnt == latched_len-1 go to PARITY (pen = 1) or STOP (pen = 0); otherwise increment bit_cnt.
- PARITY: capture the bit at the decision point; go to STOP at end of bit.
- Expected parity:
  - sp = 1: ~eps.
  - sp = 0: the bit that makes data+parity have an even count of ones (eps = 1) or an odd count (eps = 0).
- STOP: at the decision point, go to IDLE immediately (half-bit early, for resync) and drive rx_valid = 1 for exactly one pclk in that cycle, together with:
  - rx_data = shifted data, right-aligned;
  - frame_error = ~stop_bit;
  - parity_error = pen & (parity_bit != expected);
  - break_det = (data == 0) & (~pen | parity_bit == 0) & (stop_bit == 0). break_det implies frame_error.
- Status outputs hold their last value between rx_valid pulses.
- Only the first stop bit is checked. A line held low after a break does not retrigger until it has been voted high for at least one sample.
- Reset: all outputs 0 except rxd_voted = 1. State goes to IDLE and counters clear. A reset mid-frame aborts the character with no rx_valid.
- baud_tick low: all state holds.
- Latency: rx_valid occurs OVERSAMPLE/2+1 ticks into the stop bit.

Decomposition:
- Package uart_rx_pkg: state enum (IDLE/START/DATA/PARITY/STOP), MIN_WLEN = 5, and a parity-expectation function.
- Sub-module uart_rx_majority_sampler: mux, synchroniser and 3-tap vote, with output rxd_voted.
- The top level holds the FSM, counters and shift register.

Test Plan:
- Default params, loop = 1, 8N1 character 0xA5 on loop_txd -> one rx_valid, rx_data = 0xA5, all errors 0, rx_busy low afterwards.
- word_len = 7, pen = 1, eps = 1, sp = 0, character 0x55 sent with parity 1 (wrong) -> rx_data = 0x55, parity_error = 1, frame_error = 0.
- 5-bit character 0x1F with stop bit 0 -> rx_data = 0x1F, frame_error = 1, break_det = 0.
- Line held low for 2 character times -> exactly one rx_valid with rx_data = 0, frame_error = 1, break_det = 1. No further rx_valid until the line returns high and a new start bit arrives.
- Low glitch of 4 baud_ticks (< OVERSAMPLE/2) -> rx_busy pulses, no rx_valid. A back-to-back valid character is still received correctly.
- presetn = 1 for 1 cycle mid-DATA -> no rx_valid, outputs 0, next 0x3C received cleanly.
- DATA_MAX = 9, word_len = 9, stick parity (sp = 1, eps = 1), character 0x1A5 with parity 0 -> rx_data = 0x1A5, parity_error = 0.
